seven_seg_time_display: RTL and testbench



---
 rtl/seven_seg_time_display.sv | 238 +++++++++++++++++++++++
 tb/tb_seven_seg_time_display.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_time_display.sv
// Six-digit mm:ss:hh display driver for active-low 7-segment displays.
// A 9-cycle frame loop converts min/sec/hs to BCD with a serial double-dabble engine.
// A registered output stage applies the segment encoding, dashes, decimal points,
// leading-zero blanking and blinking.
module seven_seg_time_display #(
  parameter int unsigned BLINK_CNT_W = 7,
  parameter int unsigned LZ_BLANK    = 0,
  parameter int unsigned DP_EN       = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [6:0] min,
  input  logic [5:0] sec,
  input  logic [6:0] hs,
  output logic [7:0] dig5,
  output logic [7:0] dig4,
  output logic [7:0] dig3,
  output logic [7:0] dig2,
  output logic [7:0] dig1,
  output logic [7:0] dig0,
  output logic       upd
);

  typedef enum logic [1:0] {
    StLoad,
    StShift,
    StCommit
  } state_e;

  localparam logic [7:0] SegBlank = 8'hFF;
  localparam logic [7:0] SegDash  = 8'hBF;

  // One double-dabble iteration on a 3-nibble accumulator.
  // Nibbles >= 5 get +3, then the next binary bit is shifted in.
  function automatic logic [11:0] dabble(input logic [11:0] acc, input logic b);
    logic [11:0] a;
    a = acc;
    for (int i = 0; i < 3; i++) begin
      if (a[i*4 +: 4] >= 4'd5) begin
        a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
      end
    end
    return {a[10:0], b};
  endfunction

  // Active-low segment pattern for one BCD digit, dp off.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // Conversion engine state.
  state_e      state_q, state_d;
  logic [2:0]  iter_q, iter_d;
  logic [6:0]  min_sh_q, min_sh_d;
  logic [6:0]  sec_sh_q, sec_sh_d;
  logic [6:0]  hs_sh_q, hs_sh_d;
  logic [11:0] min_acc_q, min_acc_d;
  logic [11:0] sec_acc_q, sec_acc_d;
  logic [11:0] hs_acc_q, hs_acc_d;
  logic        commit;

  // Committed BCD frame feeding the display stage.
  logic [11:0] min_bcd_q, sec_bcd_q, hs_bcd_q;
  logic        have_data_q;
  logic        upd_q;

  // Blink counter and output register.
  logic [BLINK_CNT_W-1:0] blink_q;
  logic [5:0][7:0]        dig_q, dig_d;

  // Frame sequencing: load operands, shift seven times, commit.
  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    min_sh_d  = min_sh_q;
    sec_sh_d  = sec_sh_q;
    hs_sh_d   = hs_sh_q;
    min_acc_d = min_acc_q;
    sec_acc_d = sec_acc_q;
    hs_acc_d  = hs_acc_q;
    commit    = 1'b0;
    case (state_q)
      StLoad: begin
        min_sh_d  = min;
        sec_sh_d  = {1'b0, sec};
        hs_sh_d   = hs;
        min_acc_d = '0;
        sec_acc_d = '0;
        hs_acc_d  = '0;
        iter_d    = '0;
        state_d   = StShift;
      end
      StShift: begin
        min_acc_d = dabble(min_acc_q, min_sh_q[6]);
        sec_acc_d = dabble(sec_acc_q, sec_sh_q[6]);
        hs_acc_d  = dabble(hs_acc_q, hs_sh_q[6]);
        min_sh_d  = {min_sh_q[5:0], 1'b0};
        sec_sh_d  = {sec_sh_q[5:0], 1'b0};
        hs_sh_d   = {hs_sh_q[5:0], 1'b0};
        iter_d    = iter_q + 3'd1;
        if (iter_q == 3'd6) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  // Conversion engine registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StLoad;
      iter_q    <= '0;
      min_sh_q  <= '0;
      sec_sh_q  <= '0;
      hs_sh_q   <= '0;
      min_acc_q <= '0;
      sec_acc_q <= '0;
      hs_acc_q  <= '0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      min_sh_q  <= min_sh_d;
      sec_sh_q  <= sec_sh_d;
      hs_sh_q   <= hs_sh_d;
      min_acc_q <= min_acc_d;
      sec_acc_q <= sec_acc_d;
      hs_acc_q  <= hs_acc_d;
    end
  end

  // Commit a finished conversion into the BCD register and pulse upd.
  always_ff @(posedge clk) begin
    if (reset) begin
      min_bcd_q   <= '0;
      sec_bcd_q   <= '0;
      hs_bcd_q    <= '0;
      have_data_q <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      upd_q <= commit;
      if (commit) begin
        min_bcd_q   <= min_acc_q;
        sec_bcd_q   <= sec_acc_q;
        hs_bcd_q    <= hs_acc_q;
        have_data_q <= 1'b1;
      end
    end
  end

  // Free-running blink counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_q + BLINK_CNT_W'(1);
    end
  end

  logic       on_phase;
  logic       min_oor, hs_oor;
  logic [5:0] blank;
  logic [5:0][7:0] raw;

  // Encode the committed frame and apply dp, blanking and blink masks.
  always_comb begin
    on_phase = ~blink_q[BLINK_CNT_W-1];
    // A nonzero hundreds nibble means the field is above 99.
    min_oor  = (min_bcd_q[11:8] != 4'd0);
    hs_oor   = (hs_bcd_q[11:8] != 4'd0);

    raw[5] = min_oor ? SegDash : seg7(min_bcd_q[7:4]);
    raw[4] = min_oor ? SegDash : seg7(min_bcd_q[3:0]);
    raw[3] = seg7(sec_bcd_q[7:4]);
    raw[2] = seg7(sec_bcd_q[3:0]);
    raw[1] = hs_oor ? SegDash : seg7(hs_bcd_q[7:4]);
    raw[0] = hs_oor ? SegDash : seg7(hs_bcd_q[3:0]);

    if (DP_EN != 0) begin
      raw[4][7] = 1'b0;
      raw[2][7] = 1'b0;
    end

    blank = '0;
    if (!on_phase) begin
      case (mode)
        2'd1:    blank = 6'b111111;
        2'd2:    blank = 6'b110000;
        2'd3:    blank = 6'b001100;
        default: blank = 6'b000000;
      endcase
    end
    if ((LZ_BLANK != 0) && !min_oor && (min_bcd_q[7:4] == 4'd0)) begin
      blank[5] = 1'b1;
    end

    for (int i = 0; i < 6; i++) begin
      dig_d[i] = (!have_data_q || blank[i]) ? SegBlank : raw[i];
    end
  end

  // Registered segment outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      dig_q <= {6{SegBlank}};
    end else begin
      dig_q <= dig_d;
    end
  end

  assign dig5 = dig_q[5];
  assign dig4 = dig_q[4];
  assign dig3 = dig_q[3];
  assign dig2 = dig_q[2];
  assign dig1 = dig_q[1];
  assign dig0 = dig_q[0];
  assign upd  = upd_q;

endmodule

// File: tb/tb_seven_seg_time_display.sv
// Bench for seven_seg_time_display: a frame-level arithmetic model checked every cycle,
// plus directed literal expectations. Two instances cover LZ_BLANK = 0 and 1.
module tb_seven_seg_time_display;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [6:0] min = 7'd0;
  logic [5:0] sec = 6'd0;
  logic [6:0] hs = 7'd0;

  logic [7:0] s_dig5, s_dig4, s_dig3, s_dig2, s_dig1, s_dig0;
  logic [7:0] l_dig5, l_dig4, l_dig3, l_dig2, l_dig1, l_dig0;
  logic       s_upd, l_upd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seven_seg_time_display #(
    .BLINK_CNT_W(7),
    .LZ_BLANK   (0),
    .DP_EN      (1)
  ) u_std (
    .clk  (clk),
    .reset(reset),
    .mode (mode),
    .min  (min),
    .sec  (sec),
    .hs   (hs),
    .dig5 (s_dig5),
    .dig4 (s_dig4),
    .dig3 (s_dig3),
    .dig2 (s_dig2),
    .dig1 (s_dig1),
    .dig0 (s_dig0),
    .upd  (s_upd)
  );

  seven_seg_time_display #(
    .BLINK_CNT_W(7),
    .LZ_BLANK   (1),
    .DP_EN      (1)
  ) u_lz (
    .clk  (clk),
    .reset(reset),
    .mode (mode),
    .min  (min),
    .sec  (sec),
    .hs   (hs),
    .dig5 (l_dig5),
    .dig4 (l_dig4),
    .dig3 (l_dig3),
    .dig2 (l_dig2),
    .dig1 (l_dig1),
    .dig0 (l_dig0),
    .upd  (l_upd)
  );

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] seg(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [47:0] render(input int mn, input int sc, input int h, input bit have,
                                         input int md, input bit on, input bit lz);
    logic [7:0] d [6];
    bit         blk [6];
    if (!have) return {48{1'b1}};
    d[5] = (mn > 99) ? 8'hBF : seg(mn / 10);
    d[4] = (mn > 99) ? 8'hBF : seg(mn % 10);
    d[3] = seg(sc / 10);
    d[2] = seg(sc % 10);
    d[1] = (h > 99) ? 8'hBF : seg(h / 10);
    d[0] = (h > 99) ? 8'hBF : seg(h % 10);
    d[4][7] = 1'b0;
    d[2][7] = 1'b0;
    for (int i = 0; i < 6; i++) blk[i] = 1'b0;
    if (!on) begin
      if (md == 1) for (int i = 0; i < 6; i++) blk[i] = 1'b1;
      if (md == 2) begin blk[5] = 1'b1; blk[4] = 1'b1; end
      if (md == 3) begin blk[3] = 1'b1; blk[2] = 1'b1; end
    end
    if (lz && mn <= 99 && (mn / 10) == 0) blk[5] = 1'b1;
    for (int i = 0; i < 6; i++) if (blk[i]) d[i] = 8'hFF;
    return {d[5], d[4], d[3], d[2], d[1], d[0]};
  endfunction

  // edge_n counts clock edges since reset release; frames start on multiples of 9.
  int          edge_n = 0;
  int          pend_min, pend_sec, pend_hs;
  int          disp_min, disp_sec, disp_hs;
  bit          have = 1'b0;
  bit          model_ok = 1'b0;
  logic [47:0] exp_std, exp_lz;
  logic        exp_upd;

  always @(posedge clk) begin
    if (reset) begin
      edge_n   <= 0;
      have     <= 1'b0;
      exp_std  <= {48{1'b1}};
      exp_lz   <= {48{1'b1}};
      exp_upd  <= 1'b0;
      model_ok <= 1'b1;
    end else begin
      exp_std <= render(disp_min, disp_sec, disp_hs, have, int'(mode), (edge_n % 128) < 64, 1'b0);
      exp_lz  <= render(disp_min, disp_sec, disp_hs, have, int'(mode), (edge_n % 128) < 64, 1'b1);
      exp_upd <= ((edge_n % 9) == 8);
      if ((edge_n % 9) == 0) begin
        pend_min <= int'(min);
        pend_sec <= int'(sec);
        pend_hs  <= int'(hs);
      end
      if ((edge_n % 9) == 8) begin
        disp_min <= pend_min;
        disp_sec <= pend_sec;
        disp_hs  <= pend_hs;
        have     <= 1'b1;
      end
      edge_n <= edge_n + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      n_checks += 3;
      if ({s_dig5, s_dig4, s_dig3, s_dig2, s_dig1, s_dig0} !== exp_std) begin
        n_errors++;
        $display("FAIL model_std t=%0t got=%h want=%h", $time,
                 {s_dig5, s_dig4, s_dig3, s_dig2, s_dig1, s_dig0}, exp_std);
      end
      if ({l_dig5, l_dig4, l_dig3, l_dig2, l_dig1, l_dig0} !== exp_lz) begin
        n_errors++;
        $display("FAIL model_lz t=%0t got=%h want=%h", $time,
                 {l_dig5, l_dig4, l_dig3, l_dig2, l_dig1, l_dig0}, exp_lz);
      end
      if (s_upd !== exp_upd || l_upd !== exp_upd) begin
        n_errors++;
        $display("FAIL model_upd t=%0t got=%b/%b want=%b", $time, s_upd, l_upd, exp_upd);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Advance until edge_n % m == v, with a bounded wait.
  task automatic align(input int m, input int v);
    int i;
    tick(1);
    i = 0;
    while ((edge_n % m) != v && i < 300) begin
      tick(1);
      i++;
    end
    if (i >= 300) begin
      n_checks++;
      n_errors++;
      $display("FAIL align m=%0d v=%0d got=%0d", m, v, edge_n % m);
    end
  endtask

  typedef struct {int mn; int sc; int h;} vec_t;
  vec_t vecs [5] = '{'{0, 0, 0}, '{99, 59, 99}, '{127, 63, 0}, '{9, 5, 100}, '{10, 0, 1}};

  initial begin
    min = 7'd12; sec = 6'd34; hs = 7'd56; mode = 2'd0;
    tick(3);
    chk("reset_dig5", s_dig5, 8'hFF);
    chk("reset_upd", {7'd0, s_upd}, 8'h00);
    reset = 1'b0;
    tick(9);
    chk("pre_frame_dig0", s_dig0, 8'hFF);
    chk("first_upd", {7'd0, s_upd}, 8'h01);
    tick(1);
    chk("f1_dig5", s_dig5, 8'hF9);
    chk("f1_dig4", s_dig4, 8'h24);
    chk("f1_dig3", s_dig3, 8'hB0);
    chk("f1_dig2", s_dig2, 8'h19);
    chk("f1_dig1", s_dig1, 8'h92);
    chk("f1_dig0", s_dig0, 8'h82);

    // Blinking.
    mode = 2'd1;
    align(128, 10);
    chk("blink1_on_dig5", s_dig5, 8'hF9);
    align(128, 70);
    chk("blink1_off_dig5", s_dig5, 8'hFF);
    chk("blink1_off_dig0", s_dig0, 8'hFF);
    mode = 2'd2;
    align(128, 70);
    chk("blink2_off_dig5", s_dig5, 8'hFF);
    chk("blink2_off_dig4", s_dig4, 8'hFF);
    chk("blink2_off_dig3", s_dig3, 8'hB0);
    align(128, 10);
    chk("blink2_on_dig4", s_dig4, 8'h24);
    mode = 2'd3;
    align(128, 80);
    chk("blink3_off_dig3", s_dig3, 8'hFF);
    chk("blink3_off_dig2", s_dig2, 8'hFF);
    chk("blink3_off_dig5", s_dig5, 8'hF9);
    mode = 2'd0;

    // Out of range and leading-zero blanking.
    min = 7'd100; hs = 7'd127;
    tick(20);
    chk("oor_dig5", s_dig5, 8'hBF);
    chk("oor_dig4", s_dig4, 8'h3F);
    chk("oor_dig1", s_dig1, 8'hBF);
    chk("oor_dig0", s_dig0, 8'hBF);
    chk("oor_lz_dig5", l_dig5, 8'hBF);
    min = 7'd5;
    tick(20);
    chk("lz5_dig5", l_dig5, 8'hFF);
    chk("lz5_dig4", l_dig4, 8'h12);
    chk("nolz5_dig5", s_dig5, 8'hC0);
    min = 7'd0;
    tick(20);
    chk("lz0_dig5", l_dig5, 8'hFF);
    chk("lz0_dig4", l_dig4, 8'h40);

    // Assorted vectors, checked by the model each cycle.
    foreach (vecs[i]) begin
      min = 7'(vecs[i].mn); sec = 6'(vecs[i].sc); hs = 7'(vecs[i].h);
      tick(20);
    end

    // Input change during S_SHIFT does not affect the frame in flight.
    min = 7'd12; sec = 6'd34; hs = 7'd56;
    tick(20);
    align(9, 1);
    min = 7'd47;
    tick(9);
    chk("midshift_old_dig5", s_dig5, 8'hF9);
    chk("midshift_old_dig4", s_dig4, 8'h24);
    tick(9);
    chk("midshift_new_dig5", s_dig5, 8'h99);
    chk("midshift_new_dig4", s_dig4, 8'h78);

    // One-cycle reset in the middle of S_SHIFT.
    align(9, 3);
    reset = 1'b1;
    tick(1);
    chk("midreset_dig5", s_dig5, 8'hFF);
    chk("midreset_dig0", s_dig0, 8'hFF);
    chk("midreset_upd", {7'd0, s_upd}, 8'h00);
    reset = 1'b0;
    tick(9);
    chk("postreset_blank_dig0", s_dig0, 8'hFF);
    tick(1);
    chk("postreset_dig0", s_dig0, 8'h82);
    chk("postreset_dig5", s_dig5, 8'h99);
    tick(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
